// File: rtl/adv7513_i2c_arbiter.sv
// ============================================================================
// Module   : adv7513_i2c_arbiter
// Function : round-robin sharing of one i2c_master between NUM_REQ requesters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adv7513_i2c_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TXN_DELAY   = 0,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [7*NUM_REQ-1:0]   req_chip_addr,
  input  logic [8*NUM_REQ-1:0]   req_reg_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             rdata,
  output logic                   err,
  output logic [6:0]             m_chip_addr,
  output logic [7:0]             m_reg_addr,
  output logic [7:0]             m_data_in,
  output logic                   m_write_en,
  output logic                   m_read_en,
  input  logic                   m_busy,
  input  logic [2:0]             m_status,
  input  logic [7:0]             m_data_out
);

  localparam int c_ptr_w    = $clog2(NUM_REQ);
  localparam int c_to_w     = $clog2(TIMEOUT_CYC + 1);
  localparam int c_gap_w    = (TXN_DELAY > 1) ? $clog2(TXN_DELAY) : 1;
  localparam int c_gap_last_i = (TXN_DELAY > 0) ? TXN_DELAY - 1 : 0;
  localparam logic [c_to_w-1:0]  c_to_max   = c_to_w'(TIMEOUT_CYC);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(c_gap_last_i);
  localparam logic [c_ptr_w-1:0] c_last_req = c_ptr_w'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  (* syn_encoding = "safe" *) state_t r_state;
  state_t                 w_state_next;
  logic                   w_timeout;
  logic                   w_found;
  logic [c_ptr_w-1:0]     w_sel;
  logic [c_ptr_w-1:0]     r_rr_ptr;
  logic [c_ptr_w-1:0]     r_idx;
  logic                   r_rd;
  logic [c_to_w-1:0]      r_to_cnt;
  logic [c_gap_w-1:0]     r_gap_cnt;

  logic [6:0] w_chip  [NUM_REQ];
  logic [7:0] w_reg   [NUM_REQ];
  logic [7:0] w_wdata [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_chip[gi]  = req_chip_addr[7*gi +: 7];
    assign w_reg[gi]   = req_reg_addr[8*gi +: 8];
    assign w_wdata[gi] = req_wdata[8*gi +: 8];
  end

  // Scan from rr_ptr upwards; iterating backwards lets the nearest hit win.
  always_comb begin
    logic [c_ptr_w-1:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      v_idx = c_ptr_w'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (req[v_idx]) begin
        w_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

  // r_to_cnt==0 marks the first S_WAIT cycle, where m_busy is not yet valid.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if ((r_to_cnt != '0) && !m_busy) begin
          w_state_next = S_DONE;
        end else if (r_to_cnt == c_to_max) begin
          w_state_next = S_DONE;
          w_timeout    = 1'b1;
        end
      end
      S_DONE:  w_state_next = (TXN_DELAY > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (r_gap_cnt == c_gap_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_rd        <= 1'b0;
      r_to_cnt    <= '0;
      r_gap_cnt   <= '0;
      gnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_data_in   <= '0;
      m_write_en  <= 1'b0;
      m_read_en   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      ack        <= '0;
      m_write_en <= 1'b0;
      m_read_en  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            gnt         <= NUM_REQ'(1) << w_sel;
            r_idx       <= w_sel;
            r_rd        <= req_rd[w_sel];
            m_chip_addr <= w_chip[w_sel];
            m_reg_addr  <= w_reg[w_sel];
            m_data_in   <= w_wdata[w_sel];
          end
        end
        S_ISSUE: begin
          m_read_en  <= r_rd;
          m_write_en <= !r_rd;
          r_to_cnt   <= '0;
        end
        S_WAIT: begin
          if (w_state_next == S_DONE) begin
            gnt <= '0;
            ack <= gnt;
            err <= (m_status != 3'd0) | w_timeout;
            if (r_rd) rdata <= m_data_out;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_rr_ptr  <= (r_idx == c_last_req) ? '0 : r_idx + 1'b1;
          r_gap_cnt <= '0;
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adv7513_i2c_arbiter.sv
// ============================================================================
// Module   : tb_adv7513_i2c_arbiter
// Function : directed self-checking bench with a behavioural i2c_master model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adv7513_i2c_arbiter;

  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  req_rd = '0;
  logic [13:0] req_chip_addr = '0;
  logic [15:0] req_reg_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  gnt, ack;
  logic [7:0]  rdata;
  logic        err;
  logic [6:0]  m_chip_addr;
  logic [7:0]  m_reg_addr, m_data_in;
  logic        m_write_en, m_read_en;
  logic        m_busy;
  logic [2:0]  m_status;
  logic [7:0]  m_data_out;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   busy_len = 3;
  logic hold = 1'b0;
  logic nack = 1'b0;
  logic [7:0] read_val = 8'h00;
  int   mdl_cnt;
  int   wr_pulses = 0;
  int   rd_pulses = 0;
  int   gnt_multi = 0;
  int   n;
  int   wr0, rd0;

  adv7513_i2c_arbiter #(
    .NUM_REQ(2), .TXN_DELAY(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rd(req_rd),
    .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .err(err),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_busy(m_busy), .m_status(m_status), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  // i2c_master model: busy rises the cycle after a strobe, stays busy_len cycles.
  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0; m_status <= 3'd0; m_data_out <= 8'h00; mdl_cnt <= 0;
    end else if (m_write_en || m_read_en) begin
      m_busy <= 1'b1; mdl_cnt <= busy_len; m_status <= 3'd0;
    end else if (m_busy && !hold) begin
      if (mdl_cnt <= 1) begin
        m_busy <= 1'b0;
        m_status <= nack ? 3'b010 : 3'b000;
        m_data_out <= read_val;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (m_write_en) wr_pulses <= wr_pulses + 1;
    if (m_read_en)  rd_pulses <= rd_pulses + 1;
  end

  always @(negedge clk) if (gnt == 2'b11) gnt_multi <= gnt_multi + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (ack == 2'b00 && cyc < LIMIT);
    check("ack_bound", 32'(cyc < LIMIT), 32'd1);
  endtask

  task automatic wait_gnt(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (gnt == 2'b00 && cyc < LIMIT);
    check("gnt_bound", 32'(cyc < LIMIT), 32'd1);
  endtask

  task automatic wait_strobe();
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(m_write_en || m_read_en) && cyc < LIMIT);
    check("strobe_bound", 32'(cyc < LIMIT), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_strobes", 32'({m_write_en, m_read_en}), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // 1. single write from requester 0
    req_chip_addr[6:0] = 7'h72; req_reg_addr[7:0] = 8'h41; req_wdata[7:0] = 8'h10;
    req_rd = 2'b00; wr0 = wr_pulses; rd0 = rd_pulses;
    req = 2'b01;
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_chip", 32'(m_chip_addr), 32'h72);
    check("t1_reg", 32'(m_reg_addr), 32'h41);
    check("t1_wdata", 32'(m_data_in), 32'h10);
    wait_ack(n);
    req = 2'b00;
    check("t1_latency", 32'(n), 32'd6);
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_gnt_drop", 32'(gnt), 32'h0);
    check("t1_err", 32'(err), 32'h0);
    check("t1_wr_pulses", 32'(wr_pulses - wr0), 32'd1);
    check("t1_rd_pulses", 32'(rd_pulses - rd0), 32'd0);
    repeat (6) @(negedge clk);

    // 2. single read from requester 1
    req_chip_addr[13:7] = 7'h39; req_reg_addr[15:8] = 8'h00; req_rd = 2'b10;
    read_val = 8'hA5; wr0 = wr_pulses; rd0 = rd_pulses;
    req = 2'b10;
    wait_ack(n);
    req = 2'b00;
    check("t2_ack", 32'(ack), 32'h2);
    check("t2_rdata", 32'(rdata), 32'hA5);
    check("t2_err", 32'(err), 32'h0);
    check("t2_rd_pulses", 32'(rd_pulses - rd0), 32'd1);
    check("t2_wr_pulses", 32'(wr_pulses - wr0), 32'd0);
    repeat (6) @(negedge clk);

    // 3. contention, both writes; rdata must stay A5
    req_rd = 2'b00; read_val = 8'h5A;
    req = 2'b11;
    @(negedge clk);
    check("t3_first_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      check("t3_ack_order", 32'(ack), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("t3_rdata_hold", 32'(rdata), 32'hA5);
      if (i < 3) begin
        wait_gnt(n);
        check("t3_gap_cycles", 32'(n), 32'd6);
        check("t3_next_gnt", 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h1);
      end
    end
    req = 2'b00;
    check("t3_no_dual_gnt", 32'(gnt_multi), 32'd0);

    // 4. NACK, then a clean txn clears err
    nack = 1'b1;
    req = 2'b01;
    wait_ack(n);
    check("t4_nack_ack", 32'(ack), 32'h1);
    check("t4_nack_err", 32'(err), 32'h1);
    nack = 1'b0;
    wait_ack(n);
    req = 2'b00;
    check("t4_clear_err", 32'(err), 32'h0);
    repeat (6) @(negedge clk);

    // 5. timeout: master never drops busy
    hold = 1'b1; req_rd = 2'b10;
    req = 2'b10;
    wait_strobe();
    wait_ack(n);
    req = 2'b00;
    check("t5_timeout_cycles", 32'(n), 32'd101);
    check("t5_ack", 32'(ack), 32'h2);
    check("t5_err", 32'(err), 32'h1);
    hold = 1'b0;
    repeat (10) @(negedge clk);

    // 6. reset while waiting on the master
    req_rd = 2'b00;
    req = 2'b01;
    wait_strobe();
    reset = 1'b0;
    @(negedge clk);
    check("t6_gnt", 32'(gnt), 32'h0);
    check("t6_ack", 32'(ack), 32'h0);
    check("t6_err", 32'(err), 32'h0);
    check("t6_strobes", 32'({m_write_en, m_read_en}), 32'h0);
    @(negedge clk);
    check("t6_ack_in_reset", 32'(ack), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_regrant", 32'(gnt), 32'h1);
    wait_ack(n);
    req = 2'b00;
    check("t6_post_ack", 32'(ack), 32'h1);
    repeat (6) @(negedge clk);

    // 7. request dropped and fields changed mid-txn
    req_chip_addr[13:7] = 7'h2C; req_rd = 2'b00;
    req = 2'b10;
    @(negedge clk);
    check("t7_gnt", 32'(gnt), 32'h2);
    check("t7_chip", 32'(m_chip_addr), 32'h2C);
    req = 2'b00; req_chip_addr[13:7] = 7'h11;
    @(negedge clk);
    check("t7_chip_latched", 32'(m_chip_addr), 32'h2C);
    wait_ack(n);
    check("t7_ack", 32'(ack), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
